// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: byte input, key outputs and event FIFO port of ps2_key_ctrl
interface ps2_key_ctrl_if #(parameter int FIFO_DEPTH = 8);
  logic [7:0] ps2_data;
  logic ps2_ready;
  logic [7:0] key_state;
  logic [7:0] key_press;
  logic [9:0] ev_data;
  logic ev_valid;
  logic ev_pop;
  logic [$clog2(FIFO_DEPTH):0] ev_count;
  logic overflow;
  logic clr_overflow;
  modport master(output ps2_data, ps2_ready, ev_pop, clr_overflow,
                 input key_state, key_press, ev_data, ev_valid, ev_count, overflow);
  modport slave(input ps2_data, ps2_ready, ev_pop, clr_overflow,
                output key_state, key_press, ev_data, ev_valid, ev_count, overflow);
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: scan-code decoder with held-key bitmap, press pulses and FWFT event FIFO
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic clk,
  input logic rst,
  ps2_key_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;
  logic [1:0] st_q, st_d;
  logic ready_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] ks_q, ks_d, kp_q, kp_d, hit, b;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic stb, special, is_code, ext, brk, pop, full, wr_en, tmo_hit;
  logic [9:0] ev;
  // State encoding doubles as the event flags: bit0 = ext, bit1 = brk
  always_comb begin
    b = bus.ps2_data;
    stb = bus.ps2_ready & ~ready_q;
    special = b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    is_code = stb & (b != 8'hE0) & (b != 8'hF0) & ~special;
    ext = st_q[0];
    brk = st_q[1];
    ev = {ext, brk, b};
    hit = {~ext & (b == 8'h4D), ~ext & (b == 8'h76), ~ext & (b == 8'h5A), ~ext & (b == 8'h29),
           ext & (b == 8'h72), ext & (b == 8'h75), ext & (b == 8'h74), ext & (b == 8'h6B)}
          & {8{is_code}};
    tmo_hit = (st_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));
    st_d = !stb ? (tmo_hit ? IDLE : st_q) :
           (b == 8'hE0) ? EXT :
           (b == 8'hF0) ? ((st_q == EXT || st_q == EXT_BRK) ? EXT_BRK : BRK) : IDLE;
    tmo_d = (stb || st_q == IDLE || tmo_hit) ? '0 : tmo_q + 1'b1;
    ks_d = brk ? ks_q & ~hit : ks_q | hit;
    kp_d = brk ? '0 : hit & ~ks_q;
    pop = bus.ev_pop & (cnt_q != 0);
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    wr_en = is_code & (~full | pop);
    wr_d = wr_q + AW'(wr_en);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovf_d = (is_code & full & ~pop) | (ovf_q & ~bus.clr_overflow);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      ready_q <= 1'b1;
      tmo_q <= '0;
      ks_q <= '0;
      kp_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ready_q <= bus.ps2_ready;
      tmo_q <= tmo_d;
      ks_q <= ks_d;
      kp_q <= kp_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_q] <= ev;
  end
  assign bus.key_state = ks_q;
  assign bus.key_press = kp_q;
  assign bus.ev_valid = cnt_q != 0;
  assign bus.ev_data = (cnt_q != 0) ? mem_q[rd_q] : '0;
  assign bus.ev_count = cnt_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed scan-code sequences with hand-computed expectations
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] p1, p2;
  ps2_key_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();
  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic do_pop = 1'b0, input logic do_clr = 1'b0);
    @(negedge clk);
    bus.ps2_data = b;
    bus.ps2_ready = 1'b1;
    bus.ev_pop = do_pop;
    bus.clr_overflow = do_clr;
    @(posedge clk);
    #1 p1 = bus.key_press;
    @(negedge clk);
    bus.ps2_ready = 1'b0;
    bus.ev_pop = 1'b0;
    bus.clr_overflow = 1'b0;
    @(posedge clk);
    #1 p2 = bus.key_press;
  endtask
  task automatic pop_one();
    @(negedge clk);
    bus.ev_pop = 1'b1;
    @(posedge clk);
    #1 bus.ev_pop = 1'b0;
  endtask
  task automatic flush();
    for (int i = 0; i < 2 * DEPTH && bus.ev_valid; i++) pop_one();
    check("flush_empty", bus.ev_count, 0);
  endtask
  initial begin
    bus.ps2_data = 8'h00;
    bus.ps2_ready = 1'b1;
    bus.ev_pop = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_state", bus.key_state, 8'h00);
    check("rst_key_press", bus.key_press, 8'h00);
    check("rst_ev_valid", bus.ev_valid, 0);
    check("rst_ev_count", bus.ev_count, 0);
    check("rst_ev_data", bus.ev_data, 10'h000);
    check("rst_overflow", bus.overflow, 0);
    @(negedge clk) bus.ps2_ready = 1'b0;
    send(8'h29);
    check("space_press", p1, 8'h10);
    check("space_press_gone", p2, 8'h00);
    check("space_state", bus.key_state, 8'h10);
    check("space_ev_data", bus.ev_data, 10'h029);
    check("space_ev_valid", bus.ev_valid, 1);
    check("space_ev_count", bus.ev_count, 1);
    flush();
    pop_one();
    check("pop_empty_count", bus.ev_count, 0);
    check("pop_empty_valid", bus.ev_valid, 0);
    send(8'hE0);
    send(8'h6B);
    check("left_make_press", p1, 8'h01);
    check("left_make_state", bus.key_state, 8'h11);
    check("left_make_ev", bus.ev_data, 10'h26B);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("left_brk_state", bus.key_state, 8'h10);
    check("left_brk_press", p1, 8'h00);
    check("left_brk_count", bus.ev_count, 2);
    pop_one();
    check("left_brk_ev", bus.ev_data, 10'h36B);
    flush();
    send(8'hF0);
    send(8'h29);
    check("space_brk_state", bus.key_state, 8'h00);
    check("space_brk_ev", bus.ev_data, 10'h129);
    flush();
    send(8'h6B);
    check("plain_6b_state", bus.key_state, 8'h00);
    check("plain_6b_press", p1, 8'h00);
    send(8'h29);
    check("typ1_press", p1, 8'h10);
    send(8'h29);
    check("typ2_press", p1, 8'h00);
    check("typ_state", bus.key_state, 8'h10);
    check("typ_count", bus.ev_count, 3);
    check("typ_ev0", bus.ev_data, 10'h06B);
    pop_one();
    check("typ_ev1", bus.ev_data, 10'h029);
    pop_one();
    check("typ_ev2", bus.ev_data, 10'h029);
    flush();
    send(8'hE0);
    repeat (TMO) @(posedge clk);
    send(8'h75);
    check("tmo_ev", bus.ev_data, 10'h075);
    check("tmo_count", bus.ev_count, 1);
    check("tmo_state", bus.key_state, 8'h10);
    flush();
    send(8'hAA);
    send(8'hFA);
    send(8'hF0);
    send(8'hFE);
    send(8'h5A);
    check("special_count", bus.ev_count, 1);
    check("special_ev", bus.ev_data, 10'h05A);
    check("special_state", bus.key_state, 8'h30);
    check("special_press", p1, 8'h20);
    flush();
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("ovf_count", bus.ev_count, DEPTH);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_head", bus.ev_data, 10'h001);
    send(8'h0A, 1'b1);
    check("pushpop_count", bus.ev_count, DEPTH);
    check("pushpop_flag", bus.overflow, 1);
    check("pushpop_head", bus.ev_data, 10'h002);
    send(8'h0B, 1'b0, 1'b1);
    check("clr_with_drop", bus.overflow, 1);
    @(negedge clk) bus.clr_overflow = 1'b1;
    @(negedge clk) bus.clr_overflow = 1'b0;
    check("clr_overflow", bus.overflow, 0);
    for (int i = 2; i <= 8; i++) pop_one();
    check("wrap_tail", bus.ev_data, 10'h00A);
    flush();
    send(8'hE0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("midrst_state", bus.key_state, 8'h00);
    check("midrst_count", bus.ev_count, 0);
    send(8'h6B);
    check("midrst_ev", bus.ev_data, 10'h06B);
    check("midrst_left", bus.key_state, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sits between the PS/2 byte receiver and game logic.
- Consumes one received scan-code byte per rising edge of the receiver's ready level and tracks E0 (extended) and F0 (break) prefixes.
- Maintains a held-key bitmap and one-cycle press pulses for eight game keys.
- Queues every complete key event in a first-word-fall-through FIFO for a consumer such as a menu or debug display.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2.
TIMEOUT_CYC, 2000000, idle clocks after which a pending prefix is abandoned (20 ms at 100 MHz).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
ps2_data  in  8  received byte; stable while ps2_ready is high.
ps2_ready  in  1  level from receiver; a new byte is signalled by a 0->1 transition.
key_state  out  8  held-key bitmap: [0] left, [1] right, [2] up, [3] down, [4] space, [5] enter, [6] esc, [7] P.
key_press  out  8  one-cycle pulse per bit on a new press.
ev_data  out  10  FIFO head: {ext, brk, code[7:0]}.
ev_valid  out  1  FIFO non-empty.
ev_pop  in  1  consume head when ev_valid.
ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
overflow  out  1  sticky: an event was dropped because the FIFO was full.
clr_overflow  in  1  clears overflow.

Behaviour:
Clocking and reset:
- Single clock domain.
- Reset (synchronous, active-high) gives: key_state=0, key_press=0, FIFO empty (ev_valid=0, ev_count=0, ev_data=0), overflow=0, FSM=IDLE, timeout counter=0, ready_d=1.
- ready_d=1 suppresses a spurious strobe if ps2_ready is high when reset is released.

Byte strobe and latency:
- byte_stb = ps2_ready & ~ready_d; ready_d <= ps2_ready every clock.
- A byte is processed at the same edge where ready_d updates.
- key_state, FSM and FIFO state are updated after that edge.
- key_press is high for exactly the following cycle.
- ev_valid rises the cycle after the edge if the FIFO was empty.

FSM states: IDLE, EXT, BRK, EXT_BRK. On byte_stb:
- E0: go to EXT from any state.
- F0: IDLE->BRK; EXT->EXT_BRK; BRK and EXT_BRK stay.
- Special bytes 00, AA, E1, EE, FA, FE, FF: discarded, go to IDLE, no event.
- Any other byte = code:
  - form event {ext, brk, code}, where ext=1 in EXT/EXT_BRK and brk=1 in BRK/EXT_BRK;
  - push the event to the FIFO;
  - apply the key map;
  - go to IDLE.

Key map (ext flag must match exactly; e.g. non-ext 6B does not map):
- bit0 ext 6B; bit1 ext 74; bit2 ext 75; bit3 ext 72.
- bit4 29; bit5 5A; bit6 76; bit7 4D (all non-ext).
- Make sets the bit. Break clears the bit. Unmapped codes only enqueue.
- key_press bit pulses only on a make of a mapped key whose key_state bit was 0.
- Typematic repeats enqueue an event but produce no pulse.
- A break of a key that is not held still enqueues and leaves the bit at 0.

Timeout:
- Counter increments each clock while FSM != IDLE and no byte_stb; it clears on byte_stb or in IDLE.
- On reaching TIMEOUT_CYC-1, FSM goes to IDLE with no event.

FIFO:
- FWFT: ev_data is the head, valid when ev_valid=1; pop = ev_pop & ev_valid.
- ev_pop while empty is ignored.
- Push and pop in the same cycle: allowed even when full; count unchanged; no overflow.
- Push when full without pop: event dropped, overflow<=1.
- key_state and key_press still update when an event is dropped.
- clr_overflow clears overflow. If a drop happens in the same cycle, overflow stays 1.
- Pointers wrap modulo FIFO_DEPTH.

Reset mid-sequence:
- A reset between a prefix and its code discards the prefix.
- The later code byte is decoded as a make with no ext.

Test Plan:
- Reset, then ps2_ready pulses carrying 29 -> key_state=0x10, key_press=0x10 for 1 cycle, ev_data=0x029, ev_valid=1, ev_count=1.
- Bytes E0,6B then E0,F0,6B -> key_state[0] 1 then 0; FIFO holds 0x26B, then 0x36B.
- Bytes 6B alone, then 29 twice (typematic) -> key_state[0]=0; one key_press[4] pulse only; ev_count=3 (0x06B, 0x029, 0x029).
- Byte E0, then idle TIMEOUT_CYC clocks, then 75 -> event 0x075 (non-ext); key_state[2]=0.
- Bytes AA, FA, F0, FE, 5A -> only 0x05A enqueued; key_state[5]=1 (FE cancels the break).
- With FIFO_DEPTH=8, push 9 codes without popping -> ev_count=8, overflow=1, head = first code. Then pop on the same cycle as a 10th push -> count stays 8, overflow stays 1. Then clr_overflow -> overflow=0.
